// File: rtl/resp_demux1to2_if.sv
// Response-demux bus bundle: request-tag side, shared response side and the
// two requester-facing response ports.
//
// Handshake rule on every valid/ready pair in this bundle: a transfer happens
// on a rising clock edge where valid and ready are both high. Once valid is
// raised, the sender holds valid and its payload stable until that transfer
// happens. Ready may change freely and does not wait for valid.
interface resp_demux1to2_if #(
   parameter int WIDTH = 32
);
   // request-tag side (issued by the 2:1 request mux)
   logic             req_valid;
   logic             req_sel;
   logic             req_ready;
   // shared bus response side
   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_ready;
   // port A (inst) response
   logic             a_valid;
   logic [WIDTH-1:0] a_data;
   logic             a_ready;
   // port B (data) response
   logic             b_valid;
   logic [WIDTH-1:0] b_data;
   logic             b_ready;

   // demux side
   modport slave (
      input  req_valid, req_sel, rsp_valid, rsp_data, a_ready, b_ready,
      output req_ready, rsp_ready, a_valid, a_data, b_valid, b_data
   );

   // environment side (mux, bus and requesters)
   modport master (
      output req_valid, req_sel, rsp_valid, rsp_data, a_ready, b_ready,
      input  req_ready, rsp_ready, a_valid, a_data, b_valid, b_data
   );
endinterface

// File: rtl/resp_demux1to2.sv
// Return-path demux for a 2:1 request mux. Every granted request pushes its
// source tag (1 = port A, 0 = port B) into an in-order tag FIFO. Every shared
// bus response pops the head tag and is steered through a single registered
// output stage to the owning port. Responses stay strictly in order, so a
// stalled port also blocks the other port.
module resp_demux1to2 #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   resp_demux1to2_if.slave            bus,
   output logic [$clog2(DEPTH+1)-1:0] outstanding,
   output logic                       err_orphan
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // tag FIFO state
   logic [DEPTH-1:0] tag_q, tag_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // output stage state
   logic             out_valid_q, out_valid_d;
   logic             out_sel_q, out_sel_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;

   // sticky error state
   logic             err_q, err_d;

   // handshake decode
   logic full;
   logic empty;
   logic head_sel;
   logic drain;
   logic rsp_ready_c;
   logic push;
   logic pop;

   // FIFO status, output-stage drain and the two handshakes
   always_comb begin
      full        = (cnt_q == DEPTH_C);
      empty       = (cnt_q == '0);
      head_sel    = tag_q[rd_ptr_q];
      // the held response leaves when the port it belongs to accepts it
      drain       = out_valid_q & (out_sel_q ? bus.a_ready : bus.b_ready);
      // a new response fits only if the stage is empty or emptying this cycle;
      // a tag pushed this same cycle is not visible yet (no bypass)
      rsp_ready_c = ~empty & (~out_valid_q | drain);
      push        = bus.req_valid & ~full;
      pop         = bus.rsp_valid & rsp_ready_c;
   end

   // next state for tag storage, pointers and occupancy count
   always_comb begin
      tag_d    = tag_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         tag_d[wr_ptr_q] = bus.req_sel;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      // simultaneous push and pop leave the count unchanged
      if (push && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // next state for the output stage: a pop reloads it, otherwise a drain empties it
   always_comb begin
      out_valid_d = out_valid_q;
      out_sel_d   = out_sel_q;
      out_data_d  = out_data_q;
      if (pop) begin
         out_valid_d = 1'b1;
         out_sel_d   = head_sel;
         out_data_d  = bus.rsp_data;
      end else if (drain) begin
         out_valid_d = 1'b0;
      end
   end

   // orphan flag: a response with no pending tag is a protocol error; sticky until reset
   always_comb begin
      err_d = err_q | (bus.rsp_valid & empty);
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_sel_q   <= 1'b0;
         out_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         tag_q       <= tag_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_sel_q   <= out_sel_d;
         out_data_q  <= out_data_d;
         err_q       <= err_d;
      end
   end

   // port outputs: both ports see the held data, only the owner sees valid
   always_comb begin
      bus.req_ready = ~full;
      bus.rsp_ready = rsp_ready_c;
      bus.a_valid   = out_valid_q & out_sel_q;
      bus.b_valid   = out_valid_q & ~out_sel_q;
      bus.a_data    = out_data_q;
      bus.b_data    = out_data_q;
      outstanding   = cnt_q;
      err_orphan    = err_q;
   end

endmodule

// File: tb/tb_resp_demux1to2.sv
// Directed bench for resp_demux1to2 (WIDTH=32, DEPTH=4). Inputs change 1 time
// unit after each rising edge; outputs are sampled 1 more unit later, well
// away from the next active edge.
module tb_resp_demux1to2;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic       clk;
   logic       rst;
   logic [2:0] outstanding;
   logic       err_orphan;

   int checks;
   int failures;

   resp_demux1to2_if #(.WIDTH(WIDTH)) bus ();

   resp_demux1to2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .outstanding (outstanding),
      .err_orphan  (err_orphan)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // let freshly driven inputs settle before sampling
   task automatic settle();
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one request-tag push lasting a single cycle
   task automatic push_tag(input logic sel);
      bus.req_valid = 1'b1;
      bus.req_sel   = sel;
      tick();
      bus.req_valid = 1'b0;
   endtask

   logic exp_sel;

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_sel   = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_data  = '0;
      bus.a_ready   = 1'b1;
      bus.b_ready   = 1'b1;

      // T1 reset held for two cycles
      tick();
      tick();
      rst = 1'b0;
      settle();
      check("t1_a_valid", 32'(bus.a_valid), 32'd0);
      check("t1_b_valid", 32'(bus.b_valid), 32'd0);
      check("t1_req_ready", 32'(bus.req_ready), 32'd1);
      check("t1_rsp_ready", 32'(bus.rsp_ready), 32'd0);
      check("t1_outstanding", 32'(outstanding), 32'd0);
      check("t1_err_orphan", 32'(err_orphan), 32'd0);

      // T2 in-order routing A, B, A
      push_tag(1'b1);
      push_tag(1'b0);
      push_tag(1'b1);
      settle();
      check("t2_outstanding_3", 32'(outstanding), 32'd3);
      check("t2_rsp_ready_idle", 32'(bus.rsp_ready), 32'd1);
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = 32'h11;
      tick();
      bus.rsp_data = 32'h22;
      settle();
      check("t2_a_valid_11", 32'(bus.a_valid), 32'd1);
      check("t2_b_valid_11", 32'(bus.b_valid), 32'd0);
      check("t2_a_data_11", bus.a_data, 32'h11);
      check("t2_outstanding_2", 32'(outstanding), 32'd2);
      check("t2_rsp_ready_streaming", 32'(bus.rsp_ready), 32'd1);
      tick();
      bus.rsp_data = 32'h33;
      settle();
      check("t2_b_valid_22", 32'(bus.b_valid), 32'd1);
      check("t2_a_valid_22", 32'(bus.a_valid), 32'd0);
      check("t2_b_data_22", bus.b_data, 32'h22);
      check("t2_outstanding_1", 32'(outstanding), 32'd1);
      tick();
      bus.rsp_valid = 1'b0;
      settle();
      check("t2_a_valid_33", 32'(bus.a_valid), 32'd1);
      check("t2_a_data_33", bus.a_data, 32'h33);
      check("t2_outstanding_0", 32'(outstanding), 32'd0);
      check("t2_rsp_ready_empty", 32'(bus.rsp_ready), 32'd0);
      tick();
      check("t2_a_valid_drained", 32'(bus.a_valid), 32'd0);
      check("t2_b_valid_drained", 32'(bus.b_valid), 32'd0);

      // T3 fill to DEPTH, blocked push, then push+pop at 3
      push_tag(1'b0);
      push_tag(1'b1);
      push_tag(1'b0);
      push_tag(1'b1);
      settle();
      check("t3_outstanding_full", 32'(outstanding), 32'd4);
      check("t3_req_ready_full", 32'(bus.req_ready), 32'd0);
      push_tag(1'b1);
      settle();
      check("t3_outstanding_blocked", 32'(outstanding), 32'd4);
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = 32'h44;
      tick();
      bus.req_valid = 1'b1;
      bus.req_sel   = 1'b1;
      bus.rsp_data  = 32'h55;
      settle();
      check("t3_req_ready_at3", 32'(bus.req_ready), 32'd1);
      check("t3_rsp_ready_at3", 32'(bus.rsp_ready), 32'd1);
      check("t3_b_data_44", bus.b_data, 32'h44);
      check("t3_b_valid_44", 32'(bus.b_valid), 32'd1);
      tick();
      bus.req_valid = 1'b0;
      bus.rsp_data  = 32'h66;
      settle();
      check("t3_outstanding_pushpop", 32'(outstanding), 32'd3);
      check("t3_a_valid_55", 32'(bus.a_valid), 32'd1);
      check("t3_a_data_55", bus.a_data, 32'h55);
      tick();
      bus.rsp_data = 32'h77;
      settle();
      check("t3_b_valid_66", 32'(bus.b_valid), 32'd1);
      check("t3_b_data_66", bus.b_data, 32'h66);
      tick();
      bus.rsp_data = 32'h88;
      settle();
      check("t3_a_valid_77", 32'(bus.a_valid), 32'd1);
      check("t3_a_data_77", bus.a_data, 32'h77);
      tick();
      bus.rsp_valid = 1'b0;
      settle();
      check("t3_a_data_88", bus.a_data, 32'h88);
      check("t3_a_valid_88", 32'(bus.a_valid), 32'd1);
      check("t3_outstanding_done", 32'(outstanding), 32'd0);
      tick();

      // T4 backpressure on A blocks the following B response
      push_tag(1'b1);
      push_tag(1'b0);
      bus.a_ready   = 1'b0;
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = 32'hAB;
      tick();
      bus.rsp_data = 32'hCD;
      settle();
      check("t4_a_valid_held", 32'(bus.a_valid), 32'd1);
      check("t4_a_data_held", bus.a_data, 32'hAB);
      check("t4_rsp_ready_blocked", 32'(bus.rsp_ready), 32'd0);
      tick();
      check("t4_a_valid_still", 32'(bus.a_valid), 32'd1);
      check("t4_a_data_still", bus.a_data, 32'hAB);
      check("t4_b_valid_blocked", 32'(bus.b_valid), 32'd0);
      check("t4_outstanding_1", 32'(outstanding), 32'd1);
      bus.a_ready = 1'b1;
      settle();
      check("t4_rsp_ready_drain", 32'(bus.rsp_ready), 32'd1);
      tick();
      bus.rsp_valid = 1'b0;
      settle();
      check("t4_b_valid_cd", 32'(bus.b_valid), 32'd1);
      check("t4_b_data_cd", bus.b_data, 32'hCD);
      check("t4_a_valid_cleared", 32'(bus.a_valid), 32'd0);
      check("t4_outstanding_0", 32'(outstanding), 32'd0);
      tick();

      // T5 orphan response is refused and flagged stickily
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = 32'h99;
      settle();
      check("t5_rsp_ready_orphan", 32'(bus.rsp_ready), 32'd0);
      tick();
      bus.rsp_valid = 1'b0;
      settle();
      check("t5_err_set", 32'(err_orphan), 32'd1);
      check("t5_no_a_valid", 32'(bus.a_valid), 32'd0);
      check("t5_no_b_valid", 32'(bus.b_valid), 32'd0);
      tick();
      tick();
      check("t5_err_sticky", 32'(err_orphan), 32'd1);

      // reset mid-operation discards pending tags and the held response
      push_tag(1'b1);
      push_tag(1'b0);
      bus.a_ready   = 1'b0;
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = 32'h5A;
      tick();
      bus.rsp_valid = 1'b0;
      check("t5_held_before_rst", 32'(bus.a_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.a_ready = 1'b1;
      settle();
      check("t5_rst_err_clear", 32'(err_orphan), 32'd0);
      check("t5_rst_outstanding", 32'(outstanding), 32'd0);
      check("t5_rst_a_valid", 32'(bus.a_valid), 32'd0);
      check("t5_rst_a_data", bus.a_data, 32'h0);

      // T6 ten push/pop pairs wrap both pointers with alternating routing
      for (int i = 0; i < 10; i++) begin
         exp_sel = (i % 2 == 0);
         push_tag(exp_sel);
         bus.rsp_valid = 1'b1;
         bus.rsp_data  = 32'h100 + 32'(i);
         tick();
         bus.rsp_valid = 1'b0;
         settle();
         check($sformatf("t6_a_valid_%0d", i), 32'(bus.a_valid), 32'(exp_sel));
         check($sformatf("t6_b_valid_%0d", i), 32'(bus.b_valid), 32'(!exp_sel));
         check($sformatf("t6_data_%0d", i), bus.a_data, 32'h100 + 32'(i));
      end
      tick();
      check("t6_outstanding_end", 32'(outstanding), 32'd0);
      check("t6_err_end", 32'(err_orphan), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
